rmii_rx_frame: RTL and testbench

// RMII receive framer between the rmii_RX/rmii_RDV IDDR capture and the command decoder (control).

---
 rtl/rmii_pkg.sv | 13 +
 rtl/crc32_byte.sv | 17 +
 rtl/rmii_rx_frame.sv | 163 ++++++++++++++++
 tb/tb_rmii_rx_frame.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rmii_pkg.sv
// Shared constants and state type for the RMII receive framer.
package rmii_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam logic [1:0]  DIB_PRE = 2'b01;
  localparam logic [1:0]  DIB_SFD = 2'b11;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} rx_state_t;

endpackage

// File: rtl/crc32_byte.sv
// One-byte step of the reflected Ethernet CRC-32; purely combinational.
module crc32_byte
  import rmii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next_crc
);

  // Eight LSB-first shift/XOR steps
  always_comb begin
    next_crc = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      next_crc = next_crc[0] ? ((next_crc >> 1) ^ CRC32_POLY) : (next_crc >> 1);
  end

endmodule

// File: rtl/rmii_rx_frame.sv
// RMII receive framer: two dibits per clock in, preamble/SFD hunt at either
// dibit slot, LSB-first byte assembly, CRC-32 check, per-frame end status.
module rmii_rx_frame
  import rmii_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1536,
  parameter int unsigned PRE_MIN = 4
) (
  input  logic        mii_clk,
  input  logic        mii_rst_n,
  input  logic [3:0]  rmii_D,
  input  logic [1:0]  rmii_DV,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_crc_ok,
  output logic        rx_err,
  output logic [10:0] rx_len
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  localparam logic [2:0]  PRE_L = 3'(PRE_MIN);

  rx_state_t   state, state_n;
  logic [2:0]  pre_cnt, pre_n;
  logic [5:0]  sr, sr_n;        // up to three pending dibits, newest on top
  logic [1:0]  dcnt, dcnt_n;    // dibits collected toward the current byte
  logic [10:0] cnt, cnt_n;      // bytes emitted, stops at MAX_LEN
  logic        ovf, ovf_n;
  logic [31:0] crc, crc_nxt;
  logic        start, emit, sof_n, eof_n, ok_n, err_n;
  logic [7:0]  byte_n;
  logic [10:0] len_n;
  logic [1:0]  dib;

  crc32_byte u_crc (
    .crc      (crc),
    .data     (byte_n),
    .next_crc (crc_nxt)
  );

  // Walk d0 then d1 through the FSM; state may change between the two dibits
  always_comb begin
    state_n = state;
    pre_n   = pre_cnt;
    sr_n    = sr;
    dcnt_n  = dcnt;
    cnt_n   = cnt;
    ovf_n   = ovf;
    start   = 1'b0;
    emit    = 1'b0;
    byte_n  = '0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    len_n   = '0;
    dib     = '0;
    if (rmii_DV == 2'b00) begin
      // Carrier gone: close a frame in progress, leftover dibits are dropped
      if (state == DATA) begin
        eof_n = 1'b1;
        len_n = cnt;
        ok_n  = !ovf && (crc == CRC32_RESIDUE);
        err_n = (cnt < MIN_L) || ovf || (dcnt != 2'd0);
      end
      state_n = IDLE;
    end else begin
      if (state == IDLE && rmii_DV == 2'b11) begin
        state_n = PRE;
        pre_n   = '0;
      end
      for (int i = 0; i < 2; i++) begin
        dib = (i == 0) ? rmii_D[1:0] : rmii_D[3:2];
        case (state_n)
          PRE: begin
            if (dib == DIB_PRE) begin
              if (pre_n < PRE_L) pre_n = pre_n + 3'd1;
            end else if (dib == DIB_SFD && pre_n >= PRE_L) begin
              state_n = DATA;
              start   = 1'b1;
              dcnt_n  = '0;
              cnt_n   = '0;
              ovf_n   = 1'b0;
            end else begin
              state_n = DROP;
            end
          end
          DATA: begin
            // Once oversize, the rest of the frame is ignored
            if (!ovf_n) begin
              if (dcnt_n == 2'd3) begin
                dcnt_n = 2'd0;
                if (cnt_n == MAX_L) begin
                  ovf_n = 1'b1;
                end else begin
                  emit   = 1'b1;
                  byte_n = {dib, sr_n};
                  sof_n  = (cnt_n == 11'd0);
                  cnt_n  = cnt_n + 11'd1;
                end
              end else begin
                sr_n   = {dib, sr_n[5:2]};
                dcnt_n = dcnt_n + 2'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // FSM state register
  always_ff @(posedge mii_clk or negedge mii_rst_n)
    if (!mii_rst_n) state <= IDLE;
    else            state <= state_n;

  // Frame datapath: preamble count, dibit shifter, counters, running CRC
  always_ff @(posedge mii_clk or negedge mii_rst_n) begin
    if (!mii_rst_n) begin
      pre_cnt <= '0;
      sr      <= '0;
      dcnt    <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      crc     <= CRC32_INIT;
    end else begin
      pre_cnt <= pre_n;
      sr      <= sr_n;
      dcnt    <= dcnt_n;
      cnt     <= cnt_n;
      ovf     <= ovf_n;
      if (start)     crc <= CRC32_INIT;
      else if (emit) crc <= crc_nxt;
    end
  end

  // Registered outputs; status fields are zero outside the rx_eof cycle
  always_ff @(posedge mii_clk or negedge mii_rst_n) begin
    if (!mii_rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_sof    <= 1'b0;
      rx_eof    <= 1'b0;
      rx_crc_ok <= 1'b0;
      rx_err    <= 1'b0;
      rx_len    <= '0;
    end else begin
      rx_data   <= byte_n;
      rx_valid  <= emit;
      rx_sof    <= sof_n;
      rx_eof    <= eof_n;
      rx_crc_ok <= ok_n;
      rx_err    <= err_n;
      rx_len    <= len_n;
    end
  end

endmodule

// File: tb/tb_rmii_rx_frame.sv
// Bench for rmii_rx_frame: table of directed frames plus random frames,
// expectations derived from the framing rules on whole byte/dibit lists.
module tb_rmii_rx_frame;

  logic        mii_clk = 1'b0;
  logic        mii_rst_n = 1'b0;
  logic [3:0]  rmii_D = '0;
  logic [1:0]  rmii_DV = '0;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err;
  logic [10:0] rx_len;

  rmii_rx_frame dut (
    .mii_clk   (mii_clk),
    .mii_rst_n (mii_rst_n),
    .rmii_D    (rmii_D),
    .rmii_DV   (rmii_DV),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sof    (rx_sof),
    .rx_eof    (rx_eof),
    .rx_crc_ok (rx_crc_ok),
    .rx_err    (rx_err),
    .rx_len    (rx_len)
  );

  always #20 mii_clk = ~mii_clk;

  typedef logic [7:0] bq_t[$];
  typedef logic [1:0] dq_t[$];
  typedef struct { logic [7:0] d; logic sof; int c; } obyte_t;
  typedef struct { logic [10:0] len; logic ok; logic err; int c; } oeof_t;
  typedef struct {
    string name;
    int nbytes; int pre; int bad_at; int flip; int extra; bit toggle;
    int x_nvalid; bit x_eof; int x_len; bit x_ok; bit x_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int overlap = 0;
  obyte_t got_b[$];
  oeof_t  got_e[$];

  always @(posedge mii_clk) cyc <= cyc + 1;

  // Output monitor, sampled away from the active edge
  always @(negedge mii_clk) begin
    if (mii_rst_n) begin
      if (rx_valid) got_b.push_back('{rx_data, rx_sof, cyc});
      if (rx_eof)   got_e.push_back('{rx_len, rx_crc_ok, rx_err, cyc});
      if (rx_valid && rx_eof) overlap++;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Bit-serial reflected CRC-32 over a byte list
  function automatic logic [31:0] crc_of(input bq_t b);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  // n bytes total: random payload then FCS; optional single-bit corruption
  function automatic bq_t make_frame(input int n, input int flip);
    bq_t b;
    logic [31:0] f;
    for (int i = 0; i < n - 4; i++) b.push_back(8'($urandom));
    f = ~crc_of(b);
    for (int i = 0; i < 4; i++) b.push_back(8'(f >> (8 * i)));
    if (flip >= 0) b[flip] = b[flip] ^ 8'h01;
    return b;
  endfunction

  function automatic dq_t make_dibits(input int pre, input int bad_at, input bq_t b, input int extra);
    dq_t d;
    for (int i = 0; i < pre; i++) d.push_back((i == bad_at) ? 2'b10 : 2'b01);
    d.push_back(2'b11);
    foreach (b[i]) for (int k = 0; k < 4; k++) d.push_back(2'(b[i] >> (2 * k)));
    for (int i = 0; i < extra; i++) d.push_back(2'($urandom));
    return d;
  endfunction

  // Reference: what the framer must report for a whole dibit stream
  task automatic model(input dq_t d, output bq_t eb, output bit xeof, output int xlen,
                       output bit xok, output bit xerr, output bit gap);
    int s;
    int nb;
    dq_t c;
    bq_t all;
    eb = {}; xeof = 0; xlen = 0; xok = 0; xerr = 0; gap = 0;
    s = 0;
    while (s < d.size() && d[s] == 2'b01) s++;
    if (s >= d.size() || d[s] != 2'b11 || s < 4) return;
    for (int i = s + 1; i < d.size(); i++) c.push_back(d[i]);
    nb = c.size() / 4;
    for (int i = 0; i < nb; i++) all.push_back({c[4*i+3], c[4*i+2], c[4*i+1], c[4*i]});
    for (int i = 0; i < nb && i < 1536; i++) eb.push_back(all[i]);
    xeof = 1;
    xlen = (nb > 1536) ? 1536 : nb;
    xok  = (nb <= 1536) && (crc_of(all) == 32'hDEBB20E3);
    xerr = (nb < 64) || (nb > 1536) || (c.size() % 4 != 0);
    gap  = (nb > 0) && (nb <= 1536) && (c.size() % 4 == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge mii_clk);
      rmii_D  = '0;
      rmii_DV = 2'b00;
    end
  endtask

  // Two dibits per cycle; optional CRS_DV toggle tail and mid-frame reset
  task automatic drive(input dq_t d, input bit pad, input bit toggle, input int rst_at);
    int ncyc;
    ncyc = d.size() / 2;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge mii_clk);
      rmii_D  = {d[2*k+1], d[2*k]};
      rmii_DV = 2'b11;
      if (toggle && k >= ncyc - 4) rmii_DV = (k % 2 == 0) ? 2'b01 : 2'b10;
      if (pad && k == ncyc - 1) rmii_DV = 2'b01;
      if (k == rst_at) begin
        mii_rst_n = 1'b0;
        #1;
        chk("rst_mid/outputs", {rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_len, rx_data}, 0);
        idle(2);
        mii_rst_n = 1'b1;
        break;
      end
    end
    idle(6);
  endtask

  task automatic compare(input string tag, input bq_t eb, input int xnv, input bit xeof,
                         input int xlen, input bit xok, input bit xerr, input bit gap);
    int bad;
    int nsof;
    bad = 0;
    nsof = 0;
    chk({tag, "/nvalid"}, got_b.size(), xnv);
    foreach (got_b[i]) begin
      if (i >= eb.size() || got_b[i].d !== eb[i]) bad++;
      if (got_b[i].sof) nsof++;
    end
    chk({tag, "/bytes"}, bad, 0);
    if (xnv > 0) begin
      chk({tag, "/sof_first"}, (got_b.size() > 0) ? got_b[0].sof : 1'b0, 1);
      chk({tag, "/sof_count"}, nsof, 1);
    end
    chk({tag, "/neof"}, got_e.size(), xeof);
    if (xeof && got_e.size() > 0) begin
      chk({tag, "/len"}, got_e[0].len, xlen);
      chk({tag, "/crc_ok"}, got_e[0].ok, xok);
      chk({tag, "/err"}, got_e[0].err, xerr);
      if (gap && got_b.size() > 0) chk({tag, "/eof_gap"}, got_e[0].c - got_b[$].c, 1);
    end
    chk({tag, "/overlap"}, overlap, 0);
  endtask

  task automatic run_vec(input vec_t v, input bit rnd, input int rst_at);
    bq_t b, eb;
    dq_t d;
    bit pad, xeof, xok, xerr, gap;
    int xlen;
    b = make_frame(v.nbytes, v.flip);
    d = make_dibits(v.pre, v.bad_at, b, v.extra);
    pad = (d.size() % 2) != 0;
    if (pad) d.push_back(2'b00);
    model(d, eb, xeof, xlen, xok, xerr, gap);
    got_b.delete();
    got_e.delete();
    overlap = 0;
    drive(d, pad, v.toggle, rst_at);
    if (rst_at >= 0)
      chk({v.name, "/no_eof"}, got_e.size(), 0);
    else if (rnd)
      compare(v.name, eb, eb.size(), xeof, xlen, xok, xerr, gap);
    else
      compare(v.name, eb, v.x_nvalid, v.x_eof, v.x_len, v.x_ok, v.x_err, gap);
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    // 27 preamble dibits put the SFD in d1 (even phase); 28 put it in d0.
    // Odd phase ends with a lone data dibit in d0 whose partner is consumed too.
    tbl[0]  = '{"good_even",  64,   27, -1, -1, 0, 0, 64,   1, 64,   1, 0};
    tbl[1]  = '{"good_odd",   64,   28, -1, -1, 0, 0, 64,   1, 64,   1, 1};
    tbl[2]  = '{"bad_crc",    64,   27, -1, 20, 0, 0, 64,   1, 64,   0, 0};
    tbl[3]  = '{"runt",       20,   27, -1, -1, 0, 0, 20,   1, 20,   1, 1};
    tbl[4]  = '{"oversize",   2000, 27, -1, -1, 0, 0, 1536, 1, 1536, 0, 1};
    tbl[5]  = '{"dv_toggle",  64,   27, -1, -1, 0, 1, 64,   1, 64,   1, 0};
    tbl[6]  = '{"max_len",    1536, 27, -1, -1, 0, 0, 1536, 1, 1536, 1, 0};
    tbl[7]  = '{"min_len_m1", 63,   27, -1, -1, 0, 0, 63,   1, 63,   1, 1};
    tbl[8]  = '{"tail_dibits",64,   27, -1, -1, 2, 0, 64,   1, 64,   1, 1};
    tbl[9]  = '{"short_pre",  64,   3,  -1, -1, 0, 0, 0,    0, 0,    0, 0};
    tbl[10] = '{"bad_pre",    64,   27, 10, -1, 0, 0, 0,    0, 0,    0, 0};
    tbl[11] = '{"pre5",       64,   5,  -1, -1, 0, 0, 64,   1, 64,   1, 0};

    #5;
    chk("reset/outputs", {rx_valid, rx_sof, rx_eof, rx_crc_ok, rx_err, rx_len, rx_data}, 0);
    idle(3);
    mii_rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], 1'b0, -1);

    // Reset while byte 30 is on the wire, then a clean frame must decode
    run_vec(tbl[0], 1'b0, 74);
    run_vec(tbl[0], 1'b0, -1);

    for (int i = 0; i < 24; i++) begin
      rv = '{"rand", 0, 0, -1, -1, 0, 0, 0, 0, 0, 0, 0};
      rv.name   = $sformatf("rand%0d", i);
      rv.nbytes = $urandom_range(8, 120);
      rv.pre    = $urandom_range(2, 31);
      rv.bad_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, rv.pre - 1)) : -1;
      rv.flip   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rv.nbytes - 1)) : -1;
      rv.extra  = $urandom_range(0, 3);
      rv.toggle = 1'($urandom_range(0, 1));
      run_vec(rv, 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
